// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating count of bubbles that squashed a real instruction.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [9:0]       id_ctrl,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rt,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    input  logic [31:0]      id_pcplus4,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             ex_valid,
    output logic [9:0]       ex_ctrl,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_rs_data,
    output logic [31:0]      ex_rt_data,
    output logic [31:0]      ex_imm,
    output logic [31:0]      ex_pcplus4,
    output logic             stall,
    output logic [CNT_W-1:0] bubble_count
);

    // id_ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0]}
    localparam int MEM_READ_BIT = 8;

    logic             ex_valid_q, ex_valid_d;
    logic [9:0]       ex_ctrl_q, ex_ctrl_d;
    logic [4:0]       ex_rs_q, ex_rs_d;
    logic [4:0]       ex_rt_q, ex_rt_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [31:0]      ex_rs_data_q, ex_rs_data_d;
    logic [31:0]      ex_rt_data_q, ex_rt_data_d;
    logic [31:0]      ex_imm_q, ex_imm_d;
    logic [31:0]      ex_pcplus4_q, ex_pcplus4_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    logic load_use;
    logic bubble;

    // Stall semantics: stall=1 means upstream must hold PC and IF/ID this cycle;
    // the ID instruction is consumed only on an edge where stall and flush are both 0.
    always_comb begin
        load_use = ex_valid_q & ex_ctrl_q[MEM_READ_BIT] & (ex_rt_q != 5'd0) & id_valid &
                   ((ex_rt_q == id_rs) | (id_uses_rt & (ex_rt_q == id_rt)));
        bubble   = ~ex_hold & (flush | load_use);
    end

    assign stall = ex_hold | load_use;

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_rd_d        = ex_rd_q;
        ex_rs_data_d   = ex_rs_data_q;
        ex_rt_data_d   = ex_rt_data_q;
        ex_imm_d       = ex_imm_q;
        ex_pcplus4_d   = ex_pcplus4_q;
        bubble_count_d = bubble_count_q;
        if (!ex_hold) begin
            // Data fields are don't-care under a bubble, so they always follow ID.
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
            ex_rd_d      = id_rd;
            ex_rs_data_d = id_rs_data;
            ex_rt_data_d = id_rt_data;
            ex_imm_d     = id_imm;
            ex_pcplus4_d = id_pcplus4;
            if (bubble) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = 10'd0;
                if (id_valid && !(&bubble_count_q)) begin
                    bubble_count_d = bubble_count_q + CNT_W'(1);
                end
            end else begin
                ex_valid_d = id_valid;
                ex_ctrl_d  = id_valid ? id_ctrl : 10'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= 10'd0;
            ex_rs_q        <= 5'd0;
            ex_rt_q        <= 5'd0;
            ex_rd_q        <= 5'd0;
            ex_rs_data_q   <= 32'd0;
            ex_rt_data_q   <= 32'd0;
            ex_imm_q       <= 32'd0;
            ex_pcplus4_q   <= 32'd0;
            bubble_count_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_rd_q        <= ex_rd_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_pcplus4_q   <= ex_pcplus4_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_rd        = ex_rd_q;
    assign ex_rs_data   = ex_rs_data_q;
    assign ex_rt_data   = ex_rt_data_q;
    assign ex_imm       = ex_imm_q;
    assign ex_pcplus4   = ex_pcplus4_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use bubbles, flush, hold, counter
// saturation (CNT_W=4) and asynchronous reset.
module tb_id_ex_stage;

  localparam int CNT_W = 4;
  localparam logic [9:0] LW_CTRL  = 10'b1101100000;
  localparam logic [9:0] ADD_CTRL = 10'b1000010010;

  logic             clk;
  logic             reset_n;
  logic             id_valid;
  logic [9:0]       id_ctrl;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             id_uses_rt;
  logic [31:0]      id_rs_data, id_rt_data, id_imm, id_pcplus4;
  logic             flush, ex_hold;
  logic             ex_valid;
  logic [9:0]       ex_ctrl;
  logic [4:0]       ex_rs, ex_rt, ex_rd;
  logic [31:0]      ex_rs_data, ex_rt_data, ex_imm, ex_pcplus4;
  logic             stall;
  logic [CNT_W-1:0] bubble_count;

  int checks = 0;
  int passed = 0;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pcplus4(id_pcplus4),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pcplus4(ex_pcplus4),
    .stall(stall), .bubble_count(bubble_count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_id(input logic v, input logic [9:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic u,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [31:0] pc);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = u;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_pcplus4 = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    set_id(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    #3;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_count", 32'(bubble_count), 32'd0);
    check("rst_pc", ex_pcplus4, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    ex_hold = 1'b1;
    #1 check("rst_stall_hold", 32'(stall), 32'd1);
    ex_hold = 1'b0;
    tick(); tick();

    // first edge after reset loads lw $8
    set_id(1'b1, LW_CTRL, 5'd2, 5'd8, 5'd0, 1'b0, 32'd100, 32'd0, 32'd4, 32'h104);
    reset_n = 1'b1;
    tick();
    check("lw_valid", 32'(ex_valid), 32'd1);
    check("lw_ctrl", 32'(ex_ctrl), 32'(LW_CTRL));
    check("lw_rt", 32'(ex_rt), 32'd8);
    check("lw_imm", ex_imm, 32'd4);
    check("lw_pc", ex_pcplus4, 32'h104);

    // load-use on rs
    set_id(1'b1, ADD_CTRL, 5'd8, 5'd9, 5'd10, 1'b1, 32'd1, 32'd2, 32'd0, 32'h108);
    #1 check("lu_stall", 32'(stall), 32'd1);
    tick();
    check("lu_bub_valid", 32'(ex_valid), 32'd0);
    check("lu_bub_ctrl", 32'(ex_ctrl), 32'd0);
    check("lu_count", 32'(bubble_count), 32'd1);
    check("lu_stall_gone", 32'(stall), 32'd0);
    tick();
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_ctrl", 32'(ex_ctrl), 32'(ADD_CTRL));
    check("lu_add_rd", 32'(ex_rd), 32'd10);
    check("lu_add_rsd", ex_rs_data, 32'd1);

    // load-use on rt with id_uses_rt=1
    set_id(1'b1, LW_CTRL, 5'd3, 5'd12, 5'd0, 1'b0, 32'd0, 32'd0, 32'd8, 32'h10c);
    tick();
    set_id(1'b1, ADD_CTRL, 5'd4, 5'd12, 5'd13, 1'b1, 32'd5, 32'd6, 32'd0, 32'h110);
    #1 check("lurt_stall", 32'(stall), 32'd1);
    tick();
    check("lurt_valid", 32'(ex_valid), 32'd0);
    check("lurt_count", 32'(bubble_count), 32'd2);
    tick();
    check("lurt_add_pc", ex_pcplus4, 32'h110);

    // lw to $zero never stalls
    set_id(1'b1, LW_CTRL, 5'd2, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h114);
    tick();
    set_id(1'b1, ADD_CTRL, 5'd0, 5'd0, 5'd11, 1'b1, 32'd0, 32'd0, 32'd0, 32'h118);
    #1 check("zero_stall", 32'(stall), 32'd0);
    tick();
    check("zero_valid", 32'(ex_valid), 32'd1);
    check("zero_count", 32'(bubble_count), 32'd2);

    // rt match ignored when id_uses_rt=0
    set_id(1'b1, LW_CTRL, 5'd2, 5'd8, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h11c);
    tick();
    set_id(1'b1, ADD_CTRL, 5'd3, 5'd8, 5'd14, 1'b0, 32'd0, 32'd0, 32'd7, 32'h120);
    #1 check("nouse_stall", 32'(stall), 32'd0);
    tick();
    check("nouse_valid", 32'(ex_valid), 32'd1);
    check("nouse_imm", ex_imm, 32'd7);
    check("nouse_count", 32'(bubble_count), 32'd2);

    // flush with valid ID counts; flush of an empty slot does not
    flush = 1'b1;
    tick();
    check("fl_valid", 32'(ex_valid), 32'd0);
    check("fl_ctrl", 32'(ex_ctrl), 32'd0);
    check("fl_count", 32'(bubble_count), 32'd3);
    id_valid = 1'b0;
    tick();
    check("fl_empty_count", 32'(bubble_count), 32'd3);
    flush = 1'b0;

    // load an instruction, then hold for 3 cycles with flush and changing ID
    set_id(1'b1, ADD_CTRL, 5'd1, 5'd2, 5'd3, 1'b1, 32'h55, 32'h66, 32'd0, 32'h200);
    tick();
    check("pre_hold_pc", ex_pcplus4, 32'h200);
    ex_hold = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, LW_CTRL, 5'(i + 5), 5'(i + 6), 5'd0, 1'b1, 32'(i), 32'(i), 32'(i), 32'h300 + 32'(4 * i));
      #1 check("hold_stall", 32'(stall), 32'd1);
      tick();
      check("hold_pc", ex_pcplus4, 32'h200);
      check("hold_ctrl", 32'(ex_ctrl), 32'(ADD_CTRL));
      check("hold_count", 32'(bubble_count), 32'd3);
    end
    ex_hold = 1'b0; flush = 1'b0;
    set_id(1'b1, ADD_CTRL, 5'd1, 5'd2, 5'd3, 1'b1, 32'h77, 32'h88, 32'd0, 32'h400);
    tick();
    check("release_pc", ex_pcplus4, 32'h400);
    check("release_rtd", ex_rt_data, 32'h88);
    check("release_valid", 32'(ex_valid), 32'd1);

    // flush and load-use together give one bubble, one increment
    set_id(1'b1, LW_CTRL, 5'd2, 5'd8, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h404);
    tick();
    set_id(1'b1, ADD_CTRL, 5'd8, 5'd1, 5'd2, 1'b1, 32'd0, 32'd0, 32'd0, 32'h408);
    flush = 1'b1;
    tick();
    check("both_valid", 32'(ex_valid), 32'd0);
    check("both_count", 32'(bubble_count), 32'd4);

    // saturate the 4-bit counter
    for (int i = 0; i < 11; i++) tick();
    check("sat_reach", 32'(bubble_count), 32'd15);
    tick(); tick();
    check("sat_hold", 32'(bubble_count), 32'd15);
    flush = 1'b0;

    // asynchronous reset pulse between edges
    set_id(1'b1, ADD_CTRL, 5'd1, 5'd2, 5'd3, 1'b1, 32'd9, 32'd9, 32'd9, 32'h500);
    tick();
    check("prerst_valid", 32'(ex_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_ctrl", 32'(ex_ctrl), 32'd0);
    check("arst_count", 32'(bubble_count), 32'd0);
    check("arst_pc", ex_pcplus4, 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    #1 reset_n = 1'b1;
    set_id(1'b1, LW_CTRL, 5'd4, 5'd5, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h600);
    tick();
    check("post_rst_pc", ex_pcplus4, 32'h600);
    check("post_rst_ctrl", 32'(ex_ctrl), 32'(LW_CTRL));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
